// File: rtl/alu_mult_sequencer.sv
// Sits between the CPU control path and the 8-bit ALU. It passes ALU operations straight through,
// and builds MULT out of repeated ALU ADD/FORWARD steps while holding the CPU in a stall.
module alu_mult_sequencer #(
    parameter int unsigned WIDTH      = 8,
    parameter logic [2:0]  MULT_OP    = 3'b100,
    parameter bit          EARLY_EXIT = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] CPU_DATA1,
    input  logic [WIDTH-1:0] CPU_DATA2,
    input  logic [2:0]       CPU_SELECT,
    output logic [WIDTH-1:0] CPU_RESULT,
    output logic             CPU_ZERO,
    output logic             STALL,
    output logic [WIDTH-1:0] ALU_DATA1,
    output logic [WIDTH-1:0] ALU_DATA2,
    output logic [2:0]       ALU_SELECT,
    input  logic [WIDTH-1:0] ALU_RESULT,
    input  logic             ALU_ZERO
);

    localparam int unsigned CNT_W  = $clog2(WIDTH) + 1;
    localparam logic [2:0]  OP_FWD = 3'b000;
    localparam logic [2:0]  OP_ADD = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and multiply datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state, ALU port muxing and CPU result selection
    always_comb begin
        state_d    = state_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ALU_DATA1  = CPU_DATA1;
        ALU_DATA2  = CPU_DATA2;
        ALU_SELECT = CPU_SELECT;
        CPU_RESULT = ALU_RESULT;
        CPU_ZERO   = ALU_ZERO;

        unique case (state_q)
            IDLE: begin
                if (CPU_SELECT == MULT_OP) begin
                    mcand_d  = CPU_DATA1;
                    mplier_d = CPU_DATA2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = (CPU_DATA2 == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                ALU_DATA1 = acc_q;
                if (mplier_q[0]) begin
                    ALU_SELECT = OP_ADD;
                    ALU_DATA2  = mcand_q;
                    acc_d      = ALU_RESULT;
                end else begin
                    ALU_SELECT = OP_FWD;
                    ALU_DATA2  = acc_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                // Early exit fires once no set multiplier bits remain
                if ((cnt_q == CNT_W'(WIDTH - 1)) ||
                    (EARLY_EXIT && ((mplier_q >> 1) == '0))) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                CPU_RESULT = acc_q;
                CPU_ZERO   = (acc_q == '0);
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign STALL = (CPU_SELECT == MULT_OP) && (state_q != DONE);

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for alu_mult_sequencer: one instance without early exit (index 0) and one with
// early exit (index 1), each driving a small behavioural ALU.
module tb_alu_mult_sequencer;

    localparam logic [2:0] MULT_OP = 3'b100;

    logic       CLK;
    logic       RESET;
    logic [7:0] cpu_d1   [2];
    logic [7:0] cpu_d2   [2];
    logic [2:0] cpu_sel  [2];
    logic [7:0] cpu_res  [2];
    logic       cpu_zero [2];
    logic       stall    [2];
    logic [7:0] alu_d1   [2];
    logic [7:0] alu_d2   [2];
    logic [2:0] alu_sel  [2];
    logic [7:0] alu_res  [2];
    logic       alu_zero [2];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [7:0] alu_f(input logic [2:0] sel, input logic [7:0] a,
                                         input logic [7:0] b);
        case (sel)
            3'b000:  return b;
            3'b001:  return a + b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res[0]  = alu_f(alu_sel[0], alu_d1[0], alu_d2[0]);
    assign alu_res[1]  = alu_f(alu_sel[1], alu_d1[1], alu_d2[1]);
    assign alu_zero[0] = (alu_res[0] == 8'h00);
    assign alu_zero[1] = (alu_res[1] == 8'h00);

    alu_mult_sequencer #(.WIDTH(8), .MULT_OP(MULT_OP), .EARLY_EXIT(1'b0)) dut0 (
        .CLK(CLK), .RESET(RESET),
        .CPU_DATA1(cpu_d1[0]), .CPU_DATA2(cpu_d2[0]), .CPU_SELECT(cpu_sel[0]),
        .CPU_RESULT(cpu_res[0]), .CPU_ZERO(cpu_zero[0]), .STALL(stall[0]),
        .ALU_DATA1(alu_d1[0]), .ALU_DATA2(alu_d2[0]), .ALU_SELECT(alu_sel[0]),
        .ALU_RESULT(alu_res[0]), .ALU_ZERO(alu_zero[0])
    );

    alu_mult_sequencer #(.WIDTH(8), .MULT_OP(MULT_OP), .EARLY_EXIT(1'b1)) dut1 (
        .CLK(CLK), .RESET(RESET),
        .CPU_DATA1(cpu_d1[1]), .CPU_DATA2(cpu_d2[1]), .CPU_SELECT(cpu_sel[1]),
        .CPU_RESULT(cpu_res[1]), .CPU_ZERO(cpu_zero[1]), .STALL(stall[1]),
        .ALU_DATA1(alu_d1[1]), .ALU_DATA2(alu_d2[1]), .ALU_SELECT(alu_sel[1]),
        .ALU_RESULT(alu_res[1]), .ALU_ZERO(alu_zero[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Present a MULT on one instance; count stall cycles, record RUN opcodes, check DONE cycle.
    // Entered and left at #1 after a rising edge; operands are scrambled once RUN has begun.
    task automatic run_mult(input int idx, input logic [7:0] a, input logic [7:0] b,
                            input int exp_stall, input logic [31:0] exp_seq,
                            input logic [7:0] exp_res, input string tag);
        int          cycles = 0;
        logic [31:0] seq    = 0;
        bit          done   = 0;
        cpu_sel[idx] = MULT_OP;
        cpu_d1[idx]  = a;
        cpu_d2[idx]  = b;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge CLK);
            if (stall[idx]) begin
                if (c > 0) seq = (seq << 3) | 32'(alu_sel[idx]);
                cycles++;
            end else begin
                done = 1;
                check({tag, "_res"}, 32'(cpu_res[idx]), 32'(exp_res));
                check({tag, "_zero"}, 32'(cpu_zero[idx]), 32'(exp_res == 8'h00));
                check({tag, "_stalls"}, cycles, exp_stall);
                check({tag, "_seq"}, seq, exp_seq);
                check({tag, "_done_pass"}, 32'(alu_sel[idx]), 32'(MULT_OP));
            end
            @(posedge CLK);
            #1;
            if (c == 1) begin
                cpu_d1[idx] = 8'hA5;
                cpu_d2[idx] = 8'h5A;
            end
        end
        if (!done) check({tag, "_timeout"}, 0, 1);
    endtask

    task automatic go_idle();
        for (int i = 0; i < 2; i++) begin
            cpu_sel[i] = 3'b001;
            cpu_d1[i]  = 8'h00;
            cpu_d2[i]  = 8'h00;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            cpu_sel[i] = 3'b000;
            cpu_d1[i]  = 8'h00;
            cpu_d2[i]  = 8'h00;
        end
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;

        // Reset state and passthrough
        cpu_sel[1] = 3'b001; cpu_d1[1] = 8'h12; cpu_d2[1] = 8'h34;
        @(negedge CLK);
        check("rst_acc", 32'(dut1.acc_q), 0);
        check("rst_cnt", 32'(dut1.cnt_q), 0);
        check("pt_sel", 32'(alu_sel[1]), 32'h1);
        check("pt_res", 32'(cpu_res[1]), 32'h46);
        check("pt_stall", 32'(stall[1]), 0);
        check("pt_zero", 32'(cpu_zero[1]), 0);
        cpu_sel[1] = 3'b010; cpu_d1[1] = 8'h0F; cpu_d2[1] = 8'hF0;
        #1;
        check("pt_and_zero", 32'(cpu_zero[1]), 1);
        check("pt_d1", 32'(alu_d1[1]), 32'h0F);
        @(posedge CLK);
        #1;

        // Early-exit instance
        run_mult(1, 8'd5, 8'd3, 3, 32'o11, 8'd15, "m5x3");
        go_idle();
        run_mult(1, 8'd7, 8'd0, 1, 32'o0, 8'd0, "m7x0");
        go_idle();
        run_mult(1, 8'd16, 8'd16, 6, 32'o00001, 8'd0, "m16x16");
        go_idle();
        run_mult(1, 8'd255, 8'd255, 9, 32'o11111111, 8'h01, "m255x255");
        go_idle();

        // Fixed-length instance
        run_mult(0, 8'd255, 8'd255, 9, 32'o11111111, 8'h01, "f255x255");
        go_idle();
        run_mult(0, 8'd5, 8'd3, 9, 32'o11000000, 8'd15, "f5x3");
        go_idle();
        run_mult(0, 8'd7, 8'd0, 1, 32'o0, 8'd0, "f7x0");
        go_idle();

        // Reset at the third RUN edge aborts the multiply
        cpu_sel[1] = MULT_OP; cpu_d1[1] = 8'hFF; cpu_d2[1] = 8'hFF;
        repeat (3) @(posedge CLK);
        #1;
        cpu_sel[1] = 3'b000; cpu_d2[1] = 8'h77;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        check("rr_stall", 32'(stall[1]), 0);
        check("rr_acc", 32'(dut1.acc_q), 0);
        check("rr_sel", 32'(alu_sel[1]), 0);
        check("rr_res", 32'(cpu_res[1]), 32'h77);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rr_nodone", 32'(cpu_res[1]), 32'h77);
        @(posedge CLK);
        #1;

        // Back-to-back multiplies
        run_mult(1, 8'd2, 8'd3, 3, 32'o11, 8'd6, "b2x3");
        run_mult(1, 8'd4, 8'd4, 4, 32'o001, 8'd16, "b4x4");
        go_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Shares the 8-bit ALU between the CPU control path and a multi-cycle shift-add multiplier.
- Implements the ALU's unused MULT opcode (SELECT 3'b100) using only the ALU's existing ADD (3'b001) and FORWARD (3'b000) operations.
- Sits between the control unit/register file and the ALU instance:
  - Idle: transparent passthrough.
  - When a MULT is presented: takes ownership of the ALU and stalls the CPU until the product is ready.

Parameters:
- WIDTH, 8, datapath width; matches the ALU operand/result width.
- MULT_OP, 3'b100, CPU_SELECT code that triggers a multiply.
- EARLY_EXIT, 1, when 1, terminate as soon as the remaining multiplier bits are zero; when 0, always run WIDTH iterations.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- CPU_DATA1  input  WIDTH  operand 1 from the register file (multiplicand for MULT).
- CPU_DATA2  input  WIDTH  operand 2 (multiplier for MULT).
- CPU_SELECT  input  3  ALU opcode from the control unit.
- CPU_RESULT  output  WIDTH  result returned to the CPU.
- CPU_ZERO  output  1  zero flag returned to the CPU.
- STALL  output  1  high: CPU must hold PC and instruction.
- ALU_DATA1  output  WIDTH  drives the ALU DATA1.
- ALU_DATA2  output  WIDTH  drives the ALU DATA2.
- ALU_SELECT  output  3  drives the ALU SELECT.
- ALU_RESULT  input  WIDTH  from the ALU RESULT.
- ALU_ZERO  input  1  from the ALU ZERO.

Behaviour:
- States: IDLE, RUN, DONE.
- Registers: MCAND, MPLIER, ACC (all WIDTH), CNT (log2(WIDTH)+1 bits).

Reset:
- RESET sampled high at an edge sets state=IDLE and clears ACC, MCAND, MPLIER, CNT to 0.
- Reset mid-RUN aborts the multiply with no result delivered.
- After reset, outputs follow the IDLE rules.

IDLE:
- ALU_DATA1/2 and ALU_SELECT equal CPU_DATA1/2 and CPU_SELECT.
- CPU_RESULT = ALU_RESULT; CPU_ZERO = ALU_ZERO.
- If CPU_SELECT==MULT_OP at the edge, latch:
  - MCAND <= CPU_DATA1, MPLIER <= CPU_DATA2, ACC <= 0, CNT <= 0.
  - Next state: DONE if CPU_DATA2==0, else RUN.

RUN (one iteration per cycle):
- If MPLIER[0]==1: ALU_SELECT=3'b001, ALU_DATA1=ACC, ALU_DATA2=MCAND; at the edge ACC <= ALU_RESULT.
- Else: ALU_SELECT=3'b000, ALU_DATA1=ACC, ALU_DATA2=ACC; ACC unchanged.
- At every RUN edge: MCAND <= MCAND<<1 (zero fill), MPLIER <= MPLIER>>1, CNT <= CNT+1.
- Go to DONE when CNT==WIDTH-1, or when EARLY_EXIT and (MPLIER>>1)==0.
- CPU_SELECT/CPU_DATA changes during RUN are ignored; operands are latched.

DONE (exactly one cycle):
- CPU_RESULT = ACC; CPU_ZERO = (ACC==0).
- ALU ports take the passthrough values.
- Next state: IDLE unconditionally.

STALL:
- Combinational: STALL = (CPU_SELECT==MULT_OP) && (state!=DONE). It is high in the same cycle a MULT is first presented.
- STALL is high during IDLE only while a MULT is presented, and low in DONE.

Arithmetic and latency:
- Product is modulo 2^WIDTH (low byte only); additions wrap and no overflow flag is produced.
- With EARLY_EXIT=1, k = 1 + index of the highest set bit of the multiplier (k=0 if the multiplier is 0); with EARLY_EXIT=0, k = WIDTH when the multiplier is nonzero and 0 when it is 0.
- Stall cycles = 1 + k; the DONE cycle follows.
- Back-to-back MULTs: DONE -> IDLE -> capture, so the second MULT stalls starting in its first cycle.

Timing:
- CLK period must exceed the ALU combinational delay; ALU_RESULT is sampled at the RUN edge.

Test Plan:
1. Passthrough: CPU_SELECT=3'b001, DATA1=8'h12, DATA2=8'h34 -> ALU_SELECT=001, CPU_RESULT=8'h46, STALL=0, state remains IDLE.
2. MULT 5*3: CPU_SELECT=100, DATA1=5, DATA2=3 -> STALL high 3 cycles, then DONE cycle with CPU_RESULT=15, CPU_ZERO=0, STALL=0; ALU_SELECT sequence in RUN = 001, 001.
3. Zero multiplier: 7*0 -> STALL 1 cycle, DONE with CPU_RESULT=0, CPU_ZERO=1; no RUN cycles.
4. Wrap: 16*16 -> STALL 6 cycles (RUN ALU_SELECT = 000,000,000,000,001), DONE with CPU_RESULT=0, CPU_ZERO=1. Then 255*255 -> STALL 9 cycles, CPU_RESULT=8'h01. Repeat 255*255 with EARLY_EXIT=0 -> same 9 cycles and same result.
5. Reset mid-operation: start 255*255, assert RESET at the 3rd RUN edge with CPU_SELECT=000 -> next cycle state=IDLE, STALL=0, ACC=0, passthrough active, no DONE cycle.
6. Back-to-back: MULT 2*3 then MULT 4*4 with CPU operands changed mid-RUN -> results 6 and 16. CPU operand changes during RUN have no effect. One IDLE stall cycle precedes the second capture.
